// File: rtl/rst_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, parameter
// range limits and the counter sizing helper.
package rst_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } rst_state_e;

    localparam int SRC_MAX = 8;
    localparam int DOM_MAX = 8;
    localparam int CNT_MAX = 65535;

    // Width needed to hold 0..limit-1; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        int v;
        v = (limit > CNT_MAX) ? CNT_MAX : limit;
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/rst_debounce.sv
// One reset request source: 2-flop synchroniser on the active-low request,
// then a debounce filter producing an active-high filtered request level.
module rst_debounce
    import rst_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic req_n_i,
    output logic active_o
);

    logic [1:0] r_sync;
    logic       w_req;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], req_n_i};
        end
    end

    assign w_req = ~r_sync[1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign active_o = w_req;
        end else begin : g_filter
            localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] r_cnt;
            logic          r_active;

            // Any return to the current filtered level restarts the run count.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_cnt    <= '0;
                    r_active <= 1'b0;
                end else if (w_req == r_active) begin
                    r_cnt <= '0;
                end else if (r_cnt == LAST) begin
                    r_active <= w_req;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign active_o = r_active;
        end
    endgenerate

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: filters external reset requests and releases the domain
// resets in order. Optional sticky reset-cause register via RST_SEQUENCER_CAUSE_EN.
module rst_sequencer
    import rst_pkg::*;
#(
    parameter int NUM_SRC         = 2,
    parameter int NUM_DOMAINS     = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STRETCH_CYCLES  = 8,
    parameter int STAGGER_CYCLES  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NUM_SRC-1:0]     req_n_i,
    input  logic                   cause_clr_i,
    output logic [NUM_DOMAINS-1:0] rst_o,
    output logic                   done_o,
    output logic [NUM_SRC:0]       rst_cause_o
);

    localparam int CNT_W = cnt_width((STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES
                                                                       : STAGGER_CYCLES);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    logic [1:0]             r_por_sync;
    logic [NUM_SRC-1:0]     w_active;
    logic                   w_any_req;
    rst_state_e             r_state, w_state_next;
    logic [CNT_W-1:0]       r_cnt, w_cnt_next;
    logic [NUM_DOMAINS-1:0] r_rst, w_rst_next, w_rst_shift;
    logic                   r_done, w_done_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC && gi < SRC_MAX; gi++) begin : g_src
            rst_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .req_n_i (req_n_i[gi]),
                .active_o(w_active[gi])
            );
        end
        for (gi = 0; gi < NUM_DOMAINS && gi < DOM_MAX; gi++) begin : g_dom
            assign rst_o[gi] = r_rst[gi];
        end
    endgenerate

    assign w_any_req = |w_active;
    assign done_o    = r_done;

    // Releasing a domain shifts a zero in from bit 0; all-zero means every domain is out.
    assign w_rst_shift = r_rst << 1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_por_sync <= 2'b00;
            r_state    <= ST_ASSERT;
            r_cnt      <= '0;
            r_rst      <= '1;
            r_done     <= 1'b0;
        end else begin
            r_por_sync <= {r_por_sync[0], 1'b1};
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_rst      <= w_rst_next;
            r_done     <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_rst_next   = r_rst;
        w_done_next  = r_done;
        if (w_any_req) begin
            w_state_next = ST_ASSERT;
            w_cnt_next   = '0;
            w_rst_next   = '1;
            w_done_next  = 1'b0;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    w_rst_next  = '1;
                    w_done_next = 1'b0;
                    w_cnt_next  = '0;
                    if (r_por_sync[1]) begin
                        w_state_next = ST_HOLD;
                    end
                end
                ST_HOLD, ST_RELEASE: begin
                    if (r_cnt == ((r_state == ST_HOLD) ? STRETCH_LAST : STAGGER_LAST)) begin
                        w_cnt_next = '0;
                        w_rst_next = w_rst_shift;
                        if (w_rst_shift == '0) begin
                            w_state_next = ST_RUN;
                            w_done_next  = 1'b1;
                        end else begin
                            w_state_next = ST_RELEASE;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    w_done_next = 1'b1;
                end
                default: begin
                    w_state_next = ST_ASSERT;
                end
            endcase
        end
    end

`ifdef RST_SEQUENCER_CAUSE_EN
    logic [NUM_SRC-1:0] r_active_d;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC:0]   r_cause;

    assign w_rise = w_active & ~r_active_d;

    // A clear keeps only the sources activating this same cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_active_d <= '0;
            r_cause    <= {1'b1, {NUM_SRC{1'b0}}};
        end else begin
            r_active_d <= w_active;
            if (cause_clr_i) begin
                r_cause <= {1'b0, w_rise};
            end else if (|w_rise) begin
                r_cause <= {1'b0, r_cause[NUM_SRC-1:0] | w_rise};
            end
        end
    end

    assign rst_cause_o = r_cause;
`else
    logic w_unused_cause_clr;
    assign w_unused_cause_clr = cause_clr_i;
    assign rst_cause_o        = '0;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: stimulus queues expected output changes
// (cycle + value); a monitor pops and compares on every observed change.
module tb_rst_sequencer;

    localparam int NS = 2;
    localparam int ND = 3;
`ifdef RST_SEQUENCER_CAUSE_EN
    localparam logic [2:0] CAUSE_MASK = 3'b111;
`else
    localparam logic [2:0] CAUSE_MASK = 3'b000;
`endif

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          cause_clr = 1'b0;
    logic [NS-1:0] req_n     = '1;
    logic [ND-1:0] rst_o;
    logic          done;
    logic [NS:0]   cause;

    rst_sequencer #(
        .NUM_SRC        (NS),
        .NUM_DOMAINS    (ND),
        .DEBOUNCE_CYCLES(16),
        .STRETCH_CYCLES (8),
        .STAGGER_CYCLES (4)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .req_n_i    (req_n),
        .cause_clr_i(cause_clr),
        .rst_o      (rst_o),
        .done_o     (done),
        .rst_cause_o(cause)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] rst;
        logic       done;
        logic [2:0] cause;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  base;
    logic [6:0] prev_obs;

    task automatic expect_ev(input int c, input logic [2:0] r, input logic d, input logic [2:0] ca);
        ev_t e;
        e.cyc   = c;
        e.rst   = r;
        e.done  = d;
        e.cause = ca & CAUSE_MASK;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_now(input string name, input logic [2:0] r, input logic d, input logic [2:0] ca);
        n_checks++;
        if (rst_o !== r || done !== d || cause !== (ca & CAUSE_MASK)) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got rst=%b done=%b cause=%b required rst=%b done=%b cause=%b",
                     name, cyc, rst_o, done, cause, r, d, ca & CAUSE_MASK);
        end else begin
            $display("check %s cyc=%0d rst=%b done=%b cause=%b", name, cyc, rst_o, done, cause);
        end
    endtask

    // Monitor: every change of the outputs must match the next queued event.
    initial begin : monitor
        @(negedge clk);
        prev_obs = {rst_o, done, cause};
        forever begin
            @(negedge clk);
            if ({rst_o, done, cause} !== prev_obs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change cyc=%0d got rst=%b done=%b cause=%b required no change",
                             cyc, rst_o, done, cause);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.rst !== rst_o || mon_e.done !== done ||
                        mon_e.cause !== cause) begin
                        n_fail++;
                        $display("FAIL event cyc=%0d rst=%b done=%b cause=%b required cyc=%0d rst=%b done=%b cause=%b",
                                 cyc, rst_o, done, cause, mon_e.cyc, mon_e.rst, mon_e.done, mon_e.cause);
                    end else begin
                        $display("event cyc=%0d rst=%b done=%b cause=%b", cyc, rst_o, done, cause);
                    end
                end
                prev_obs = {rst_o, done, cause};
            end
        end
    end

    initial begin : stimulus
        #1 rst_n = 1'b0;
        wait_to(2);
        check_now("reset_state", 3'b111, 1'b0, 3'b100);

        // Power-on: first edge sampling rst_n high is base+1 (edge 0).
        wait_to(3);
        base = 3;
        expect_ev(base + 11, 3'b110, 1'b0, 3'b100);
        expect_ev(base + 15, 3'b100, 1'b0, 3'b100);
        expect_ev(base + 19, 3'b000, 1'b1, 3'b100);
        rst_n = 1'b1;
        wait_to(40);

        // Button on source 0, held 40 cycles.
        base = 40;
        expect_ev(base + 19, 3'b111, 1'b0, 3'b001);
        req_n[0] = 1'b0;
        wait_to(base + 40);
        expect_ev(base + 67, 3'b110, 1'b0, 3'b001);
        expect_ev(base + 71, 3'b100, 1'b0, 3'b001);
        expect_ev(base + 75, 3'b000, 1'b1, 3'b001);
        req_n[0] = 1'b1;
        wait_to(base + 90);

        // Standalone cause clear.
        base = 130;
`ifdef RST_SEQUENCER_CAUSE_EN
        expect_ev(base + 1, 3'b000, 1'b1, 3'b000);
`endif
        cause_clr = 1'b1;
        wait_to(base + 1);
        cause_clr = 1'b0;
        wait_to(base + 10);

        // Glitch on source 1 shorter than the debounce window.
        base = 140;
        req_n[1] = 1'b0;
        wait_to(base + 10);
        req_n[1] = 1'b1;
        wait_to(base + 50);
        check_now("after_glitch", 3'b000, 1'b1, 3'b000);

        // Source 0 reset, then source 1 accepted mid-release.
        base = 190;
        expect_ev(base + 19, 3'b111, 1'b0, 3'b001);
        req_n[0] = 1'b0;
        wait_to(base + 20);
        expect_ev(base + 47, 3'b110, 1'b0, 3'b001);
        req_n[0] = 1'b1;
        wait_to(base + 30);
        expect_ev(base + 49, 3'b111, 1'b0, 3'b011);
        req_n[1] = 1'b0;
        wait_to(base + 50);
        expect_ev(base + 77, 3'b110, 1'b0, 3'b011);
        expect_ev(base + 81, 3'b100, 1'b0, 3'b011);
        expect_ev(base + 85, 3'b000, 1'b1, 3'b011);
        req_n[1] = 1'b1;
        wait_to(base + 100);

        // Clear in the same cycle source 0 activates: set wins, old bits go.
        base = 290;
        expect_ev(base + 19, 3'b111, 1'b0, 3'b001);
        req_n[0] = 1'b0;
        wait_to(base + 18);
        cause_clr = 1'b1;
        wait_to(base + 19);
        cause_clr = 1'b0;
        wait_to(base + 40);
        expect_ev(base + 67, 3'b110, 1'b0, 3'b001);
        expect_ev(base + 71, 3'b100, 1'b0, 3'b001);
        expect_ev(base + 75, 3'b000, 1'b1, 3'b001);
        req_n[0] = 1'b1;
        wait_to(base + 90);

        // Asynchronous reset while domains are being released.
        base = 380;
        expect_ev(base + 19, 3'b111, 1'b0, 3'b011);
        req_n[1] = 1'b0;
        wait_to(base + 20);
        expect_ev(base + 47, 3'b110, 1'b0, 3'b011);
        req_n[1] = 1'b1;
        wait_to(base + 48);
        expect_ev(base + 49, 3'b111, 1'b0, 3'b100);
        @(posedge clk);
        #1 rst_n = 1'b0;
        wait_to(base + 55);
        base = base + 55;
        expect_ev(base + 11, 3'b110, 1'b0, 3'b100);
        expect_ev(base + 15, 3'b100, 1'b0, 3'b100);
        expect_ev(base + 19, 3'b000, 1'b1, 3'b100);
        rst_n = 1'b1;
        wait_to(base + 30);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events got %0d outstanding required 0 (next at cyc=%0d)",
                     exp_q.size(), exp_q[0].cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
